// File: rtl/uart_receiver_if.sv
// uart_receiver_if: groups the baud tick, serial line and received-word
// outputs of the UART receiver.
//   baud_i       - 1-cycle oversample tick (driven by master)
//   rx_i         - serial line, idles high (driven by master)
//   data_o       - last received word (driven by slave)
//   rx_done_o    - 1-cycle pulse, data/error outputs valid (slave)
//   frame_err_o  - stop bit sampled low (slave)
//   parity_err_o - parity mismatch (slave)
//   busy_o       - receiver not idle (slave)
interface uart_receiver_if #(
  parameter int WORD_BITS = 8
);
  logic                 baud_i;
  logic                 rx_i;
  logic [WORD_BITS-1:0] data_o;
  logic                 rx_done_o;
  logic                 frame_err_o;
  logic                 parity_err_o;
  logic                 busy_o;

  modport slave (
    input  baud_i, rx_i,
    output data_o, rx_done_o, frame_err_o, parity_err_o, busy_o
  );

  modport master (
    output baud_i, rx_i,
    input  data_o, rx_done_o, frame_err_o, parity_err_o, busy_o
  );
endinterface

// File: rtl/uart_receiver.sv
// uart_receiver: oversampling serial-to-parallel UART receiver.
// Samples each bit at mid-bit, assembles an LSB-first word and pulses
// rx_done_o with the word plus framing/parity status.
//   clk_i    - clock
//   reset_ni - asynchronous active-low reset
//   bus      - uart_receiver_if.slave (baud tick, rx line, word outputs)
module uart_receiver #(
  parameter int WORD_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int STOP_TICKS = 16,
  parameter int PARITY     = 0   // 0 none, 1 odd, 2 even
) (
  input  logic            clk_i,
  input  logic            reset_ni,
  uart_receiver_if.slave  bus
);

  localparam int TMAX = (OVERSAMPLE > STOP_TICKS) ? OVERSAMPLE : STOP_TICKS;
  localparam int TW   = $clog2(TMAX);
  localparam int NW   = $clog2(WORD_BITS);

  localparam logic [TW-1:0] T_MID  = TW'(OVERSAMPLE/2 - 1);
  localparam logic [TW-1:0] T_BIT  = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] T_STOP = TW'(STOP_TICKS - 1);
  localparam logic [NW-1:0] N_LAST = NW'(WORD_BITS - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_e;

  state_e               state_q, state_d;
  logic [1:0]           sync_q;
  logic                 rx_s;
  logic [TW-1:0]        tick_q, tick_d;
  logic [NW-1:0]        nbits_q, nbits_d;
  logic [WORD_BITS-1:0] word_q, word_d;
  logic [WORD_BITS-1:0] data_q, data_d;
  logic                 armed_q, armed_d;
  logic                 perr_q, perr_d;     // parity result of the frame in flight
  logic                 done_q, done_d;
  logic                 ferr_q, ferr_d;
  logic                 perr_o_q, perr_o_d; // parity result published with done

  assign rx_s = sync_q[1];

  // State register
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q  <= S_IDLE;
      sync_q   <= 2'b11;
      tick_q   <= '0;
      nbits_q  <= '0;
      word_q   <= '0;
      data_q   <= '0;
      armed_q  <= 1'b0;
      perr_q   <= 1'b0;
      done_q   <= 1'b0;
      ferr_q   <= 1'b0;
      perr_o_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      sync_q   <= {sync_q[0], bus.rx_i};
      tick_q   <= tick_d;
      nbits_q  <= nbits_d;
      word_q   <= word_d;
      data_q   <= data_d;
      armed_q  <= armed_d;
      perr_q   <= perr_d;
      done_q   <= done_d;
      ferr_q   <= ferr_d;
      perr_o_q <= perr_o_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d  = state_q;
    tick_d   = tick_q;
    nbits_d  = nbits_q;
    word_d   = word_q;
    data_d   = data_q;
    armed_d  = armed_q;
    perr_d   = perr_q;
    done_d   = 1'b0;
    ferr_d   = ferr_q;
    perr_o_d = perr_o_q;
    case (state_q)
      // baud_i is ignored here so an edge coinciding with a tick is still taken.
      // armed blocks a line stuck low (break / failed stop) from retriggering.
      S_IDLE: begin
        if (armed_q && !rx_s) begin
          state_d = S_START;
          tick_d  = '0;
          armed_d = 1'b0;
        end else if (rx_s) begin
          armed_d = 1'b1;
        end
      end
      S_START: if (bus.baud_i) begin
        if (tick_q == T_MID) begin
          if (!rx_s) begin
            state_d = S_DATA;
            tick_d  = '0;
            nbits_d = '0;
          end else begin
            state_d = S_IDLE;   // glitch: start bit gone by mid-bit
          end
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
      S_DATA: if (bus.baud_i) begin
        if (tick_q == T_BIT) begin
          word_d = {rx_s, word_q[WORD_BITS-1:1]};
          tick_d = '0;
          if (nbits_q == N_LAST) state_d = (PARITY != 0) ? S_PAR : S_STOP;
          else                   nbits_d = nbits_q + 1'b1;
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
      S_PAR: if (bus.baud_i) begin
        if (tick_q == T_BIT) begin
          tick_d  = '0;
          state_d = S_STOP;
          perr_d  = (PARITY == 2) ? (^word_q ^ rx_s) : ~(^word_q ^ rx_s);
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
      S_STOP: if (bus.baud_i) begin
        if (tick_q == T_STOP) begin
          data_d   = word_q;
          ferr_d   = ~rx_s;
          perr_o_d = (PARITY != 0) ? perr_q : 1'b0;
          done_d   = 1'b1;
          state_d  = S_IDLE;
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    bus.data_o       = data_q;
    bus.rx_done_o    = done_q;
    bus.frame_err_o  = ferr_q;
    bus.parity_err_o = perr_o_q;
    bus.busy_o       = (state_q != S_IDLE);
  end

endmodule
